cafea_vending_fsm: RTL and testbench



---
 rtl/automat_cafea_pkg.sv | 18 +
 rtl/cafea_vending_fsm.sv | 76 +++++++
 tb/tb_cafea_vending_fsm.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/automat_cafea_pkg.sv
// Shared constants and types for the coffee vending controller:
// coin values, the coffee price and the width of the lei arithmetic.
package automat_cafea_pkg;

    localparam int PRICE    = 2;
    localparam int VAL_1LEU = 1;
    localparam int VAL_5LEI = 5;
    localparam int W        = 3;

    typedef logic [W-1:0] lei_t;

    // The controller either accepts coins or is busy paying out change.
    typedef enum logic {
        MODE_ACCEPT = 1'b0,
        MODE_CHANGE = 1'b1
    } mode_t;

endpackage

// File: rtl/cafea_vending_fsm.sv
// Coin-operated coffee vending controller: credits 1-leu and 5-lei coins,
// dispenses one coffee at PRICE and pays out the excess one leu per cycle.
module cafea_vending_fsm #(
    parameter int PRICE = automat_cafea_pkg::PRICE,
    parameter int W     = automat_cafea_pkg::W
) (
    input  logic clk,
    input  logic reset,
    input  logic B1leu,
    input  logic B5lei,
    output logic cafea,
    output logic rest
);

    import automat_cafea_pkg::*;

    logic         credit;
    logic [W-1:0] chg;
    logic         cafea_q;

    logic         credit_d;
    logic [W-1:0] chg_d;
    logic         cafea_d;
    logic [W-1:0] sum;
    mode_t        mode;

    // Coins are worth nothing while change is still being returned.
    assign mode = (chg != '0) ? MODE_CHANGE : MODE_ACCEPT;

    assign sum = W'(credit)
               + (B1leu ? W'(VAL_1LEU) : '0)
               + (B5lei ? W'(VAL_5LEI) : '0);

    // NOTE: every next-state value gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        credit_d = credit;
        chg_d    = chg;
        cafea_d  = 1'b0;
        unique case (mode)
            MODE_CHANGE: begin
                chg_d = chg - W'(1);
            end
            MODE_ACCEPT: begin
                if (sum >= W'(PRICE)) begin
                    cafea_d  = 1'b1;
                    chg_d    = sum - W'(PRICE);
                    credit_d = 1'b0;
                end else begin
                    credit_d = sum[0];
                end
            end
            default: begin
                chg_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit  <= 1'b0;
            chg     <= '0;
            cafea_q <= 1'b0;
        end else begin
            credit  <= credit_d;
            chg     <= chg_d;
            cafea_q <= cafea_d;
        end
    end

    assign rest  = (chg != '0);
    assign cafea = cafea_q;

endmodule

// File: tb/tb_cafea_vending_fsm.sv
// Scoreboard bench for cafea_vending_fsm: a sale-level model queues the
// expected (cafea, rest) per edge and a monitor compares after each edge.
module tb_cafea_vending_fsm;

    localparam int PRICE = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic B1leu = 1'b0;
    logic B5lei = 1'b0;
    logic cafea;
    logic rest;

    int total = 0;
    int bad   = 0;

    // exp_q: expected {cafea, rest} after each upcoming edge.
    // plan:  outputs already committed by a sale in progress.
    logic [1:0] exp_q[$];
    logic [1:0] plan[$];
    int credit = 0;

    cafea_vending_fsm dut (
        .clk   (clk),
        .reset (reset),
        .B1leu (B1leu),
        .B5lei (B5lei),
        .cafea (cafea),
        .rest  (rest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus; the model decides the sale outcome in whole lei.
    task automatic cycle(input logic b1, input logic b5);
        @(negedge clk);
        B1leu = b1;
        B5lei = b5;
        if (plan.size() == 0) begin
            int tot;
            tot = credit + (b1 ? 1 : 0) + (b5 ? 5 : 0);
            if (tot >= PRICE) begin
                int n;
                n = tot - PRICE;
                plan.push_back({1'b1, n > 0});
                for (int i = 1; i < n; i++) plan.push_back(2'b01);
                if (n > 0) plan.push_back(2'b00);
                credit = 0;
            end else begin
                credit = tot;
            end
        end
        if (plan.size() > 0) exp_q.push_back(plan.pop_front());
        else exp_q.push_back(2'b00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        B1leu = 1'($urandom);
        B5lei = 1'($urandom);
        reset = 1'b0;
        #1;
        check("rst_cafea_async", cafea, 0);
        check("rst_rest_async", rest, 0);
        @(posedge clk);
        #1;
        check("rst_cafea_held", cafea, 0);
        check("rst_rest_held", rest, 0);
        @(negedge clk);
        reset = 1'b1;
        B1leu = 1'b0;
        B5lei = 1'b0;
        credit = 0;
        plan.delete();
    endtask

    // Monitor: compares the DUT after every edge for which a prediction exists.
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cafea", cafea, e[1]);
                check("rest", rest, e[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Power-on reset with outputs checked while asserted.
        #2;
        B1leu = 1'($urandom);
        B5lei = 1'($urandom);
        #1;
        check("por_cafea", cafea, 0);
        check("por_rest", rest, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        B1leu = 1'b0;
        B5lei = 1'b0;
        idle(5);

        // Two single lei: exact price, no change.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        idle(2);

        // 5 lei: change 3, a coin during payout is lost.
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        idle(3);
        cycle(1'b1, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0);
        idle(2);

        // Credit survives idle time: 1 + 5 gives change 4.
        cycle(1'b1, 1'b0);
        idle(3);
        cycle(0, 1'b1);
        idle(5);

        // Both coins with credit 1: change 5, then a lone leu only credits.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        idle(6);
        cycle(1'b1, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0);
        idle(2);

        // Reset during the second change cycle discards everything.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 1'b0);
        idle(1);
        cycle(1'b1, 1'b0);
        idle(2);

        // Random coin traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
            end
        end
        idle(8);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
